// File: rtl/uart_msg_sequencer.sv
// Streams a canned game message, an optional decimal value and CR LF into uart_tx
// one byte at a time over its send/busy handshake.
module uart_msg_sequencer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] msg_id,
    input  logic [7:0] value,
    input  logic       show_val,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    id_q, id_d;
    logic          show_q, show_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_send_q, tx_send_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [7:0]    sh_q, sh_d;
    logic [3:0]    dab_q, dab_d;
    logic          latch;

    logic [3:0]  tlen, ndig, vlen, msg_len, dpos;
    logic [3:0]  dig;
    logic [7:0]  cur_byte;
    logic [11:0] bcd_adj;

    function automatic logic [3:0] text_len(input logic [1:0] id);
        case (id)
            2'd0:    return 4'd7;
            2'd1:    return 4'd8;
            2'd2:    return 4'd7;
            default: return 4'd6;
        endcase
    endfunction

    // Strings are right-aligned in 64 bits: character k sits at byte (len-1-k).
    function automatic logic [7:0] text_char(input logic [1:0] id, input logic [3:0] k);
        logic [63:0] s;
        int          l;
        case (id)
            2'd0:    s = 64'h00544F4F204C4F57;  // TOO LOW
            2'd1:    s = 64'h544F4F2048494748;  // TOO HIGH
            2'd2:    s = 64'h00434F5252454354;  // CORRECT
            default: s = 64'h00004755455353_3A; // GUESS:
        endcase
        l = int'(text_len(id));
        if (int'(k) < l) return s[8*(l-1-int'(k)) +: 8];
        return 8'h00;
    endfunction

    // Byte selection for the current index.
    always_comb begin
        tlen    = text_len(id_q);
        ndig    = (bcd_q[11:8] != 4'd0) ? 4'd3 : (bcd_q[7:4] != 4'd0) ? 4'd2 : 4'd1;
        vlen    = show_q ? (4'd1 + ndig) : 4'd0;
        msg_len = tlen + vlen + 4'd2;
        dpos    = idx_q - tlen - 4'd1 + (4'd3 - ndig);
        case (dpos[1:0])
            2'd0:    dig = bcd_q[11:8];
            2'd1:    dig = bcd_q[7:4];
            default: dig = bcd_q[3:0];
        endcase
        if (idx_q < tlen)
            cur_byte = text_char(id_q, idx_q);
        else if (idx_q < tlen + vlen)
            cur_byte = (idx_q == tlen) ? 8'h20 : {4'h3, dig};
        else if (idx_q == tlen + vlen)
            cur_byte = 8'h0D;
        else
            cur_byte = 8'h0A;
    end

    // Double-dabble: finishes in 8 cycles, long before the first digit byte.
    always_comb begin
        for (int n = 0; n < 3; n++)
            bcd_adj[4*n +: 4] = (bcd_q[4*n +: 4] >= 4'd5) ? bcd_q[4*n +: 4] + 4'd3 : bcd_q[4*n +: 4];
        bcd_d = bcd_q;
        sh_d  = sh_q;
        dab_d = dab_q;
        if (latch) begin
            bcd_d = 12'd0;
            sh_d  = value;
            dab_d = 4'd8;
        end else if (dab_q != 4'd0) begin
            {bcd_d, sh_d} = {bcd_adj[10:0], sh_q, 1'b0};
            dab_d         = dab_q - 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        show_d    = show_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        latch     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    latch   = 1'b1;
                    id_d    = msg_id;
                    show_d  = show_val;
                    idx_d   = 4'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d = cur_byte;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tx_send_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // busy takes priority over a timeout reached in the same cycle
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q == msg_len - 4'd1) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            id_q      <= 2'd0;
            show_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            bcd_q     <= 12'd0;
            sh_q      <= 8'd0;
            dab_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            show_q    <= show_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            bcd_q     <= bcd_d;
            sh_q      <= sh_d;
            dab_q     <= dab_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;

endmodule
